// File: rtl/ring_req_inj_arb.sv
// ring_req_inj_arb: per-tile ring stop for the request ring.
// Each cycle the incoming slot is ejected to the tile, dropped as unclaimed,
// forwarded downstream, or (when free) refilled from the local injection FIFO.
// Ring traffic always wins over local injection. All results appear one cycle
// later on the Q501H outputs.
//
// Ports:
//   QClk, RstQnnnH          clock, asynchronous active-high reset
//   CoreID                  this tile's ID (static after reset)
//   RingIn*Q500H            incoming ring slot
//   RingOut*Q501H           registered outgoing ring slot
//   LocReq*                 local injection request (valid/ready handshake)
//   Ej*Q501H                ejected request to the tile (no backpressure)
//   UnclaimedDropQ501H      one-cycle pulse when a looped request is dropped
//   Starve                  local FIFO blocked for at least STARVE_TH cycles
//   FifoCount               local FIFO occupancy

package ring_req_inj_arb_pkg;
    typedef logic [3:0] t_opcode;

    typedef struct packed {
        logic [9:0]  requestor;
        t_opcode     opcode;
        logic [31:0] address;
        logic [31:0] data;
    } t_req;
endpackage

module ring_req_inj_arb
    import ring_req_inj_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STARVE_TH  = 16
) (
    input  logic                          QClk,
    input  logic                          RstQnnnH,
    input  logic [7:0]                    CoreID,
    input  logic                          RingInValidQ500H,
    input  logic [9:0]                    RingInRequestorQ500H,
    input  t_opcode                       RingInOpcodeQ500H,
    input  logic [31:0]                   RingInAddressQ500H,
    input  logic [31:0]                   RingInDataQ500H,
    output logic                          RingOutValidQ501H,
    output logic [9:0]                    RingOutRequestorQ501H,
    output t_opcode                       RingOutOpcodeQ501H,
    output logic [31:0]                   RingOutAddressQ501H,
    output logic [31:0]                   RingOutDataQ501H,
    input  logic                          LocReqValid,
    output logic                          LocReqReady,
    input  logic [9:0]                    LocReqRequestor,
    input  t_opcode                       LocReqOpcode,
    input  logic [31:0]                   LocReqAddress,
    input  logic [31:0]                   LocReqData,
    output logic                          EjValidQ501H,
    output logic [9:0]                    EjRequestorQ501H,
    output t_opcode                       EjOpcodeQ501H,
    output logic [31:0]                   EjAddressQ501H,
    output logic [31:0]                   EjDataQ501H,
    output logic                          UnclaimedDropQ501H,
    output logic                          Starve,
    output logic [$clog2(FIFO_DEPTH):0]   FifoCount
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Slot classification
    logic w_eject, w_unclaimed, w_forward, w_free;
    logic w_empty, w_push, w_pop;
    t_req w_ring_in, w_loc_req, w_head;

    // FIFO state
    t_req             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count, w_count_d;

    // Starvation state
    logic [7:0] r_starve_cnt, w_starve_cnt_d;
    logic       r_starve;

    // Output registers
    logic r_ring_valid, r_ej_valid, r_drop;
    t_req r_ring_out, r_ej_out;

    assign w_ring_in = '{requestor: RingInRequestorQ500H, opcode: RingInOpcodeQ500H,
                         address: RingInAddressQ500H, data: RingInDataQ500H};
    assign w_loc_req = '{requestor: LocReqRequestor, opcode: LocReqOpcode,
                         address: LocReqAddress, data: LocReqData};

    // Invalid slots are ignored entirely, including destination/requestor fields.
    assign w_eject     = RingInValidQ500H && (RingInAddressQ500H[31:24] == CoreID);
    assign w_unclaimed = RingInValidQ500H && !w_eject && (RingInRequestorQ500H[9:2] == CoreID);
    assign w_forward   = RingInValidQ500H && !w_eject && !w_unclaimed;
    assign w_free      = !w_forward;

    assign w_empty     = (r_count == '0);
    // Ready is based on the registered count only: a full FIFO refuses a push
    // even in a cycle where it pops.
    assign LocReqReady = (r_count < CNT_W'(FIFO_DEPTH));
    assign w_push      = LocReqValid && LocReqReady;
    assign w_pop       = w_free && !w_empty;
    assign w_head      = r_mem[r_rptr];

    always_comb begin
        w_count_d = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + CNT_W'(1);
            2'b01:   w_count_d = r_count - CNT_W'(1);
            default: w_count_d = r_count;
        endcase
    end

    always_comb begin
        w_starve_cnt_d = r_starve_cnt;
        if (w_pop || w_empty) begin
            w_starve_cnt_d = '0;
        end else if (w_forward && (r_starve_cnt != 8'hFF)) begin
            w_starve_cnt_d = r_starve_cnt + 8'd1;
        end
    end

    // Storage is not reset; only the pointers and count define its contents.
    always_ff @(posedge QClk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_loc_req;
        end
    end

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_starve_cnt <= '0;
            r_starve     <= 1'b0;
            r_ring_valid <= 1'b0;
            r_ring_out   <= '0;
            r_ej_valid   <= 1'b0;
            r_ej_out     <= '0;
            r_drop       <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            r_count      <= w_count_d;
            r_starve_cnt <= w_starve_cnt_d;
            r_starve     <= (w_starve_cnt_d >= 8'(STARVE_TH));

            if (w_forward) begin
                r_ring_valid <= 1'b1;
                r_ring_out   <= w_ring_in;
            end else if (w_pop) begin
                r_ring_valid <= 1'b1;
                r_ring_out   <= w_head;
            end else begin
                r_ring_valid <= 1'b0;
            end

            r_ej_valid <= w_eject;
            if (w_eject) r_ej_out <= w_ring_in;

            r_drop <= w_unclaimed;
        end
    end

    assign RingOutValidQ501H     = r_ring_valid;
    assign RingOutRequestorQ501H = r_ring_out.requestor;
    assign RingOutOpcodeQ501H    = r_ring_out.opcode;
    assign RingOutAddressQ501H   = r_ring_out.address;
    assign RingOutDataQ501H      = r_ring_out.data;
    assign EjValidQ501H          = r_ej_valid;
    assign EjRequestorQ501H      = r_ej_out.requestor;
    assign EjOpcodeQ501H         = r_ej_out.opcode;
    assign EjAddressQ501H        = r_ej_out.address;
    assign EjDataQ501H           = r_ej_out.data;
    assign UnclaimedDropQ501H    = r_drop;
    assign Starve                = r_starve;
    assign FifoCount             = r_count;

endmodule

// File: tb/tb_ring_req_inj_arb.sv
// Directed bench for ring_req_inj_arb (CoreID = 2, FIFO_DEPTH = 4, STARVE_TH = 16).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.

module tb_ring_req_inj_arb;
    import ring_req_inj_arb_pkg::*;

    logic        QClk;
    logic        RstQnnnH;
    logic [7:0]  CoreID;
    logic        RingInValidQ500H;
    logic [9:0]  RingInRequestorQ500H;
    t_opcode     RingInOpcodeQ500H;
    logic [31:0] RingInAddressQ500H;
    logic [31:0] RingInDataQ500H;
    logic        RingOutValidQ501H;
    logic [9:0]  RingOutRequestorQ501H;
    t_opcode     RingOutOpcodeQ501H;
    logic [31:0] RingOutAddressQ501H;
    logic [31:0] RingOutDataQ501H;
    logic        LocReqValid;
    logic        LocReqReady;
    logic [9:0]  LocReqRequestor;
    t_opcode     LocReqOpcode;
    logic [31:0] LocReqAddress;
    logic [31:0] LocReqData;
    logic        EjValidQ501H;
    logic [9:0]  EjRequestorQ501H;
    t_opcode     EjOpcodeQ501H;
    logic [31:0] EjAddressQ501H;
    logic [31:0] EjDataQ501H;
    logic        UnclaimedDropQ501H;
    logic        Starve;
    logic [2:0]  FifoCount;

    int checks = 0;
    int errors = 0;

    ring_req_inj_arb #(.FIFO_DEPTH(4), .STARVE_TH(16)) dut (
        .QClk                  (QClk),
        .RstQnnnH              (RstQnnnH),
        .CoreID                (CoreID),
        .RingInValidQ500H      (RingInValidQ500H),
        .RingInRequestorQ500H  (RingInRequestorQ500H),
        .RingInOpcodeQ500H     (RingInOpcodeQ500H),
        .RingInAddressQ500H    (RingInAddressQ500H),
        .RingInDataQ500H       (RingInDataQ500H),
        .RingOutValidQ501H     (RingOutValidQ501H),
        .RingOutRequestorQ501H (RingOutRequestorQ501H),
        .RingOutOpcodeQ501H    (RingOutOpcodeQ501H),
        .RingOutAddressQ501H   (RingOutAddressQ501H),
        .RingOutDataQ501H      (RingOutDataQ501H),
        .LocReqValid           (LocReqValid),
        .LocReqReady           (LocReqReady),
        .LocReqRequestor       (LocReqRequestor),
        .LocReqOpcode          (LocReqOpcode),
        .LocReqAddress         (LocReqAddress),
        .LocReqData            (LocReqData),
        .EjValidQ501H          (EjValidQ501H),
        .EjRequestorQ501H      (EjRequestorQ501H),
        .EjOpcodeQ501H         (EjOpcodeQ501H),
        .EjAddressQ501H        (EjAddressQ501H),
        .EjDataQ501H           (EjDataQ501H),
        .UnclaimedDropQ501H    (UnclaimedDropQ501H),
        .Starve                (Starve),
        .FifoCount             (FifoCount)
    );

    initial QClk = 1'b0;
    always #5 QClk = ~QClk;

    task automatic step();
        @(posedge QClk);
        #1;
    endtask

    task automatic set_slot(input logic v, input logic [9:0] req, input logic [31:0] addr,
                            input logic [31:0] data);
        RingInValidQ500H     = v;
        RingInRequestorQ500H = req;
        RingInOpcodeQ500H    = 4'h3;
        RingInAddressQ500H   = addr;
        RingInDataQ500H      = data;
    endtask

    task automatic set_loc(input logic v, input logic [31:0] addr, input logic [31:0] data);
        LocReqValid     = v;
        LocReqRequestor = 10'h008;
        LocReqOpcode    = 4'h5;
        LocReqAddress   = addr;
        LocReqData      = data;
    endtask

    task automatic test_reset();
        RstQnnnH = 1'b1;
        CoreID   = 8'd2;
        set_slot(1'b0, 10'h0, 32'h0, 32'h0);
        set_loc(1'b0, 32'h0, 32'h0);
        repeat (2) step();
        checks++;
        if ({RingOutValidQ501H, EjValidQ501H, UnclaimedDropQ501H, Starve} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 0000",
                     {RingOutValidQ501H, EjValidQ501H, UnclaimedDropQ501H, Starve});
        end
        checks++;
        if ({RingOutAddressQ501H, RingOutDataQ501H, EjDataQ501H} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got %h exp 0",
                     {RingOutAddressQ501H, RingOutDataQ501H, EjDataQ501H});
        end
        checks++;
        if (FifoCount !== 3'd0 || LocReqReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo: got count %0d ready %b exp 0 1", FifoCount, LocReqReady);
        end
        @(negedge QClk);
        RstQnnnH = 1'b0;
    endtask

    task automatic test_forward();
        set_slot(1'b1, 10'h004, 32'h0300_0010, 32'h1234_5678);
        step();
        checks++;
        if (RingOutValidQ501H !== 1'b1 || RingOutAddressQ501H !== 32'h0300_0010 ||
            RingOutRequestorQ501H !== 10'h004 || RingOutDataQ501H !== 32'h1234_5678 ||
            RingOutOpcodeQ501H !== 4'h3) begin
            errors++;
            $display("FAIL forward: got v%b a%h r%h d%h o%h exp v1 a03000010 r004 d12345678 o3",
                     RingOutValidQ501H, RingOutAddressQ501H, RingOutRequestorQ501H,
                     RingOutDataQ501H, RingOutOpcodeQ501H);
        end
        checks++;
        if (EjValidQ501H !== 1'b0 || FifoCount !== 3'd0) begin
            errors++;
            $display("FAIL forward_side: got ej %b count %0d exp 0 0", EjValidQ501H, FifoCount);
        end
        set_slot(1'b0, 10'h0, 32'h0, 32'h0);
        step();
        checks++;
        if (RingOutValidQ501H !== 1'b0 || RingOutAddressQ501H !== 32'h0300_0010) begin
            errors++;
            $display("FAIL idle_hold: got v%b a%h exp v0 a03000010",
                     RingOutValidQ501H, RingOutAddressQ501H);
        end
    endtask

    task automatic test_eject_inject();
        // Push into an empty FIFO with an idle ring: nothing may leave this cycle.
        set_loc(1'b1, 32'h0100_0000, 32'h1111_1111);
        step();
        checks++;
        if (RingOutValidQ501H !== 1'b0 || FifoCount !== 3'd1) begin
            errors++;
            $display("FAIL no_bypass: got v%b count %0d exp v0 count 1",
                     RingOutValidQ501H, FifoCount);
        end
        set_loc(1'b0, 32'h0, 32'h0);
        set_slot(1'b1, 10'h010, 32'h0200_0044, 32'hDEAD_BEEF);
        step();
        checks++;
        if (EjValidQ501H !== 1'b1 || EjDataQ501H !== 32'hDEAD_BEEF ||
            EjAddressQ501H !== 32'h0200_0044 || EjRequestorQ501H !== 10'h010) begin
            errors++;
            $display("FAIL eject: got v%b d%h a%h r%h exp v1 dDEADBEEF a02000044 r010",
                     EjValidQ501H, EjDataQ501H, EjAddressQ501H, EjRequestorQ501H);
        end
        checks++;
        if (RingOutValidQ501H !== 1'b1 || RingOutAddressQ501H !== 32'h0100_0000 ||
            RingOutDataQ501H !== 32'h1111_1111 || RingOutOpcodeQ501H !== 4'h5 ||
            FifoCount !== 3'd0) begin
            errors++;
            $display("FAIL eject_inject: got v%b a%h d%h o%h count %0d exp v1 a01000000 d11111111 o5 0",
                     RingOutValidQ501H, RingOutAddressQ501H, RingOutDataQ501H,
                     RingOutOpcodeQ501H, FifoCount);
        end
        set_slot(1'b0, 10'h0, 32'h0, 32'h0);
        step();
        checks++;
        if (EjValidQ501H !== 1'b0 || EjDataQ501H !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ej_hold: got v%b d%h exp v0 dDEADBEEF", EjValidQ501H, EjDataQ501H);
        end
    endtask

    task automatic test_starve();
        logic [31:0] a [4];
        for (int i = 0; i < 4; i++) a[i] = 32'h0A00_0000 + 32'(i);
        set_slot(1'b1, 10'h004, 32'h0500_0000, 32'h5555_0000);
        for (int i = 0; i < 4; i++) begin
            set_loc(1'b1, a[i], 32'hA0 + 32'(i));
            checks++;
            if (LocReqReady !== 1'b1) begin
                errors++;
                $display("FAIL starve_ready%0d: got %b exp 1", i, LocReqReady);
            end
            step();
        end
        checks++;
        if (LocReqReady !== 1'b0 || FifoCount !== 3'd4) begin
            errors++;
            $display("FAIL full: got ready %b count %0d exp 0 4", LocReqReady, FifoCount);
        end
        // Keep offering a 5th request; it must be refused while full.
        set_loc(1'b1, 32'h0AFF_FFFF, 32'hFF);
        repeat (11) step();
        checks++;
        if (Starve !== 1'b0 || FifoCount !== 3'd4 || RingOutAddressQ501H !== 32'h0500_0000 ||
            RingOutValidQ501H !== 1'b1) begin
            errors++;
            $display("FAIL starve_early: got starve %b count %0d a%h v%b exp 0 4 a05000000 v1",
                     Starve, FifoCount, RingOutAddressQ501H, RingOutValidQ501H);
        end
        repeat (3) step();
        checks++;
        if (Starve !== 1'b1) begin
            errors++;
            $display("FAIL starve_set: got %b exp 1", Starve);
        end
        set_loc(1'b0, 32'h0, 32'h0);
        set_slot(1'b0, 10'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (RingOutValidQ501H !== 1'b1 || RingOutAddressQ501H !== a[i]) begin
                errors++;
                $display("FAIL drain%0d: got v%b a%h exp v1 a%h",
                         i, RingOutValidQ501H, RingOutAddressQ501H, a[i]);
            end
        end
        checks++;
        if (Starve !== 1'b0 || FifoCount !== 3'd0) begin
            errors++;
            $display("FAIL starve_clear: got starve %b count %0d exp 0 0", Starve, FifoCount);
        end
        step();
        checks++;
        if (RingOutValidQ501H !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got %b exp 0", RingOutValidQ501H);
        end
    endtask

    task automatic test_unclaimed();
        set_slot(1'b1, 10'h009, 32'h0700_0000, 32'h7777_7777);
        step();
        checks++;
        if (UnclaimedDropQ501H !== 1'b1 || RingOutValidQ501H !== 1'b0 || EjValidQ501H !== 1'b0) begin
            errors++;
            $display("FAIL unclaimed: got drop %b ring %b ej %b exp 1 0 0",
                     UnclaimedDropQ501H, RingOutValidQ501H, EjValidQ501H);
        end
        set_slot(1'b0, 10'h009, 32'h0200_0000, 32'h0);
        step();
        checks++;
        if (UnclaimedDropQ501H !== 1'b0 || EjValidQ501H !== 1'b0) begin
            errors++;
            $display("FAIL unclaimed_pulse: got drop %b ej %b exp 0 0",
                     UnclaimedDropQ501H, EjValidQ501H);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = 32'h0B00_0000 + 32'(i);
        set_slot(1'b1, 10'h004, 32'h0600_0000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            set_loc(1'b1, b[i], 32'(i));
            step();
        end
        set_slot(1'b0, 10'h0, 32'h0, 32'h0);
        set_loc(1'b1, 32'h0BBB_BBBB, 32'h0);
        checks++;
        if (LocReqReady !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b exp 0", LocReqReady);
        end
        step();
        checks++;
        if (FifoCount !== 3'd3 || RingOutValidQ501H !== 1'b1 || RingOutAddressQ501H !== b[0]) begin
            errors++;
            $display("FAIL full_pushpop: got count %0d v%b a%h exp 3 v1 a%h",
                     FifoCount, RingOutValidQ501H, RingOutAddressQ501H, b[0]);
        end
        set_loc(1'b0, 32'h0, 32'h0);
        for (int i = 1; i < 4; i++) begin
            step();
            checks++;
            if (RingOutValidQ501H !== 1'b1 || RingOutAddressQ501H !== b[i]) begin
                errors++;
                $display("FAIL full_drain%0d: got v%b a%h exp v1 a%h",
                         i, RingOutValidQ501H, RingOutAddressQ501H, b[i]);
            end
        end
        step();
        checks++;
        if (RingOutValidQ501H !== 1'b0 || FifoCount !== 3'd0) begin
            errors++;
            $display("FAIL full_rejected: got v%b count %0d exp v0 0", RingOutValidQ501H, FifoCount);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] c [9];
        for (int i = 0; i < 9; i++) c[i] = 32'h0C00_0000 + 32'(i * 16);
        set_slot(1'b0, 10'h0, 32'h0, 32'h0);
        for (int i = 0; i < 9; i++) begin
            set_loc(1'b1, c[i], 32'(i));
            step();
            checks++;
            if (i == 0) begin
                if (RingOutValidQ501H !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap0: got v%b exp v0", RingOutValidQ501H);
                end
            end else if (RingOutValidQ501H !== 1'b1 || RingOutAddressQ501H !== c[i-1] ||
                         FifoCount !== 3'd1) begin
                errors++;
                $display("FAIL wrap%0d: got v%b a%h count %0d exp v1 a%h 1",
                         i, RingOutValidQ501H, RingOutAddressQ501H, FifoCount, c[i-1]);
            end
        end
        set_loc(1'b0, 32'h0, 32'h0);
        step();
        checks++;
        if (RingOutValidQ501H !== 1'b1 || RingOutAddressQ501H !== c[8] || FifoCount !== 3'd0) begin
            errors++;
            $display("FAIL wrap_last: got v%b a%h count %0d exp v1 a%h 0",
                     RingOutValidQ501H, RingOutAddressQ501H, FifoCount, c[8]);
        end
    endtask

    task automatic test_async_reset();
        set_slot(1'b1, 10'h004, 32'h0400_0000, 32'h4444_4444);
        for (int i = 0; i < 3; i++) begin
            set_loc(1'b1, 32'h0D00_0000 + 32'(i), 32'(i));
            step();
        end
        set_loc(1'b0, 32'h0, 32'h0);
        step();
        checks++;
        if (FifoCount !== 3'd3 || RingOutValidQ501H !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got count %0d v%b exp 3 v1", FifoCount, RingOutValidQ501H);
        end
        #3;
        RstQnnnH = 1'b1;
        #1;
        checks++;
        if (RingOutValidQ501H !== 1'b0 || RingOutAddressQ501H !== 32'h0 || FifoCount !== 3'd0 ||
            EjDataQ501H !== 32'h0 || LocReqReady !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got v%b a%h count %0d ej%h ready %b exp v0 a0 0 0 1",
                     RingOutValidQ501H, RingOutAddressQ501H, FifoCount, EjDataQ501H, LocReqReady);
        end
        @(negedge QClk);
        RstQnnnH = 1'b0;
        set_slot(1'b0, 10'h0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (RingOutValidQ501H !== 1'b0 || FifoCount !== 3'd0) begin
                errors++;
                $display("FAIL post_reset%0d: got v%b count %0d exp v0 0",
                         i, RingOutValidQ501H, FifoCount);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_eject_inject();
        test_starve();
        test_unclaimed();
        test_full_push_pop();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_req_inj_arb.md
Name: ring_req_inj_arb

Overview:
- Per-tile ring-stop arbiter for the LOTR request ring. It sits between the incoming ring segment and the outgoing ring segment of one tile.
- Each cycle it either ejects the incoming request slot to the local tile, forwards it downstream, or fills an empty slot with a request from a local injection FIFO.
- Ring traffic always has priority over local injection. The block tracks local starvation and drops requests that have circled back to their originator unclaimed.

Parameters:
- FIFO_DEPTH, 4, local injection FIFO entries; power of two, minimum 2.
- STARVE_TH, 16, consecutive blocked cycles before Starve asserts; maximum 255.

Ports:
- QClk  in  1  clock
- RstQnnnH  in  1  asynchronous active-high reset
- CoreID  in  8  this tile's ID; static after reset
- RingInValidQ500H  in  1  incoming slot valid
- RingInRequestorQ500H  in  10  originator; [9:2] is core ID, [1:0] is thread
- RingInOpcodeQ500H  in  t_opcode  request opcode
- RingInAddressQ500H  in  32  address; [31:24] is destination core ID
- RingInDataQ500H  in  32  write data
- RingOutValidQ501H / RingOutRequestorQ501H / RingOutOpcodeQ501H / RingOutAddressQ501H / RingOutDataQ501H  out  1/10/t_opcode/32/32  registered outgoing slot
- LocReqValid  in  1  local request valid
- LocReqReady  out  1  local request accepted when Valid and Ready are both high
- LocReqRequestor / LocReqOpcode / LocReqAddress / LocReqData  in  10/t_opcode/32/32  local request fields
- EjValidQ501H  out  1  ejected request valid; no backpressure, the tile must accept it
- EjRequestorQ501H / EjOpcodeQ501H / EjAddressQ501H / EjDataQ501H  out  10/t_opcode/32/32  ejected request fields
- UnclaimedDropQ501H  out  1  one-cycle pulse when a request is dropped as unclaimed
- Starve  out  1  local FIFO blocked for at least STARVE_TH cycles
- FifoCount  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, RstQnnnH high):
  - FIFO is emptied and both pointers go to 0.
  - All Q501H outputs go to 0, including all data fields.
  - UnclaimedDropQ501H=0, Starve=0, starvation counter=0, FifoCount=0.
  - Reset asserted mid-operation discards all FIFO contents and any in-flight slot.
- Slot classification, combinational on the Q500H inputs:
  - Eject: Valid && Address[31:24]==CoreID.
  - Unclaimed: Valid && not Eject && Requestor[9:2]==CoreID. The request has made a full loop without a taker.
  - Forward: Valid && neither of the above.
  - Free: !Valid, or Eject, or Unclaimed.
- Priority each cycle, all results registered to Q501H (fixed 1-cycle latency):
  - Forward: RingOut gets the input fields; the FIFO is not popped.
  - Free with FIFO non-empty: RingOut gets the FIFO head with Valid=1, and the FIFO is popped. Injection may happen in the same cycle as an eject or an unclaimed drop.
  - Free with FIFO empty: RingOutValid=0 and the data fields are held at their previous value.
  - Eject: EjValid=1 with the input fields. Otherwise EjValid=0 and the Ej fields are held.
  - Unclaimed: UnclaimedDropQ501H=1 and the request is discarded.
- FIFO rules:
  - LocReqReady = (FifoCount < FIFO_DEPTH). Ready does not depend on a same-cycle pop, so a full FIFO rejects pushes even when popping.
  - Push and pop in the same cycle leaves the count unchanged.
  - There is no bypass path: a request pushed into an empty FIFO is injected no earlier than the next cycle, so LocReq to RingOut takes at least 2 cycles.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Ordering is strict FIFO.
- Starvation counter:
  - Increments when FIFO is non-empty and the slot is Forward.
  - Clears on any pop, or when the FIFO is empty.
  - Saturates at 255.
  - Starve = (counter >= STARVE_TH), registered.
  - Status only: ring traffic is never stalled or dropped because of starvation.
- Local requests addressed to CoreID itself are injected normally. They are ejected by this block after one full loop; they are not short-circuited.
- Ring slot data with Valid=0 is ignored, including the destination and requestor fields.

Test Plan:
- Reset, then CoreID=8'd2 and FIFO empty: drive an input slot with Valid=1, Addr=0x0300_0010, Req=0x004 -> next cycle RingOutValid=1 with identical fields, EjValid=0, FifoCount=0.
- Input slot with Addr=0x0200_0044, Data=0xDEAD_BEEF, FIFO holding one entry (Addr=0x0100_0000) -> next cycle EjValid=1 with Data=0xDEAD_BEEF; RingOut carries the local entry with Valid=1; FifoCount goes 1 to 0.
- Push 4 local requests (A0..A3) while the ring is saturated with Forward slots -> LocReqReady=0 after the 4th push; Starve=1 once 16 blocked cycles have elapsed. Then drive 4 idle slots -> A0..A3 appear in order on consecutive cycles and Starve clears.
- Input slot with Req[9:2]=8'd2, Addr[31:24]=8'd7, FIFO empty -> UnclaimedDropQ501H pulses for exactly 1 cycle, RingOutValid=0, EjValid=0.
- FIFO full, drive a push and a pop in the same cycle -> push is rejected (Ready=0), FifoCount goes 4 to 3. Wrap-around: push/pop 9 entries through FIFO_DEPTH=4 -> output order is preserved.
- Assert RstQnnnH asynchronously while FifoCount=3 and RingOutValid=1 -> all outputs go to 0 immediately, and after deassertion no stale entries are injected.
